// File: rtl/spi_cmd_tx.sv
// Serial command transmitter for the PSEC5 SPI slave: sends one {data, addr} frame,
// address byte first, LSB first, with a programmable sclk half-period and trailing gap.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for tx_valid; tx_ready high, sclk and serial_out low
// SHIFT_LO | sclk low half-period; serial_out presents sreg[0]
// SHIFT_HI | sclk high half-period; shift and count bit on final cycle
// GAP      | sclk and serial_out low for GAP_CYCLES after the last bit

module spi_cmd_tx #(
    parameter int unsigned HALF_PERIOD = 1,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic       iclk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_addr,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       sclk,
    output logic       serial_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        GAP      = 2'd3
    } state_t;

    // Terminal counts for the shared phase/gap timer; 8 bits covers 1..255.
    localparam logic [7:0] HALF_TC = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] GAP_TC  = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] sreg, sreg_nxt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  div_cnt, div_cnt_nxt;
    logic        done_nxt;

    always_ff @(posedge iclk) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= 16'd0;
            bit_cnt <= 5'd0;
            div_cnt <= 8'd0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            sreg    <= sreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            div_cnt <= div_cnt_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sreg_nxt    = sreg;
        bit_cnt_nxt = bit_cnt;
        div_cnt_nxt = div_cnt;
        done_nxt    = 1'b0;
        tx_ready    = 1'b0;
        busy        = 1'b1;
        sclk        = 1'b0;
        serial_out  = 1'b0;

        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (tx_valid) begin
                    sreg_nxt    = {tx_data, tx_addr};
                    bit_cnt_nxt = 5'd0;
                    div_cnt_nxt = 8'd0;
                    state_nxt   = SHIFT_LO;
                end
            end

            SHIFT_LO: begin
                serial_out = sreg[0];
                if (div_cnt == HALF_TC) begin
                    div_cnt_nxt = 8'd0;
                    state_nxt   = SHIFT_HI;
                end else begin
                    div_cnt_nxt = div_cnt + 8'd1;
                end
            end

            SHIFT_HI: begin
                sclk       = 1'b1;
                serial_out = sreg[0];
                if (div_cnt == HALF_TC) begin
                    // Shift lands after the falling edge, so data only moves while sclk is low.
                    div_cnt_nxt = 8'd0;
                    sreg_nxt    = {1'b0, sreg[15:1]};
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd15) begin
                        if (GAP_CYCLES == 0) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = GAP;
                        end
                    end else begin
                        state_nxt = SHIFT_LO;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 8'd1;
                end
            end

            GAP: begin
                if (div_cnt == GAP_TC) begin
                    div_cnt_nxt = 8'd0;
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
                end else begin
                    div_cnt_nxt = div_cnt + 8'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_cmd_tx.sv
// Directed bench for spi_cmd_tx: one DUT at HALF_PERIOD=1 and one at HALF_PERIOD=3,
// per-cycle output history captured and decoded into sclk-rise samples.

module tb_spi_cmd_tx;

    logic       iclk = 1'b0;
    logic       rst;
    logic       v1, v3;
    logic [7:0] a1, d1, a3, d3;
    logic       r1, s1, so1, b1, dn1;
    logic       r3, s3, so3, b3, dn3;

    int checks = 0;
    int fails  = 0;

    logic sc_h  [0:255];
    logic so_h  [0:255];
    logic dn_h  [0:255];
    logic rdy_h [0:255];

    always #5 iclk = ~iclk;

    spi_cmd_tx #(.HALF_PERIOD(1), .GAP_CYCLES(2)) dut1 (
        .iclk(iclk), .rst(rst), .tx_valid(v1), .tx_addr(a1), .tx_data(d1),
        .tx_ready(r1), .sclk(s1), .serial_out(so1), .busy(b1), .done(dn1)
    );

    spi_cmd_tx #(.HALF_PERIOD(3), .GAP_CYCLES(2)) dut3 (
        .iclk(iclk), .rst(rst), .tx_valid(v3), .tx_addr(a3), .tx_data(d3),
        .tx_ready(r3), .sclk(s3), .serial_out(so3), .busy(b3), .done(dn3)
    );

    // Record ncyc cycles of outputs; index k is sampled 1 time unit after the k-th edge.
    task automatic capture(input int which, input int ncyc);
        sc_h[0] = 1'b0;
        so_h[0] = 1'b0;
        dn_h[0] = 1'b0;
        rdy_h[0] = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge iclk);
            #1;
            sc_h[k]  = (which == 1) ? s1  : s3;
            so_h[k]  = (which == 1) ? so1 : so3;
            dn_h[k]  = (which == 1) ? dn1 : dn3;
            rdy_h[k] = (which == 1) ? r1  : r3;
        end
    endtask

    task automatic analyze(input int ncyc, output int nrise, output logic [31:0] bits,
                           output int first_rise, output int first_done,
                           output int last_done, output int ndone);
        nrise = 0; bits = '0; first_rise = -1; first_done = -1; last_done = -1; ndone = 0;
        for (int k = 1; k <= ncyc; k++) begin
            if (sc_h[k] && !sc_h[k-1]) begin
                if (nrise < 32) bits[nrise] = so_h[k];
                if (first_rise < 0) first_rise = k;
                nrise++;
            end
            if (dn_h[k]) begin
                if (first_done < 0) first_done = k;
                last_done = k;
                ndone++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; v1 = 1'b0; v3 = 1'b0;
        a1 = 8'h00; d1 = 8'h00; a3 = 8'h00; d3 = 8'h00;
        repeat (3) @(posedge iclk);
        #1;
        checks++; if ({r1, b1, dn1, s1, so1} !== 5'b10000) begin
            fails++; $display("FAIL reset_outputs_h1: got %b expected 10000", {r1, b1, dn1, s1, so1});
        end
        checks++; if ({r3, b3, dn3, s3, so3} !== 5'b10000) begin
            fails++; $display("FAIL reset_outputs_h3: got %b expected 10000", {r3, b3, dn3, s3, so3});
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        int nr, fr, fd, ld, nd;
        logic [31:0] bits;
        a1 = 8'h01; d1 = 8'hAA; v1 = 1'b1;
        fork
            capture(1, 40);
            begin @(posedge iclk); #2 v1 = 1'b0; end
        join
        analyze(40, nr, bits, fr, fd, ld, nd);
        checks++; if (nr !== 16) begin
            fails++; $display("FAIL basic_rises: got %0d expected 16", nr);
        end
        checks++; if (bits[15:0] !== 16'hAA01) begin
            fails++; $display("FAIL basic_bits: got %h expected aa01", bits[15:0]);
        end
        checks++; if (so_h[1] !== 1'b1 || rdy_h[1] !== 1'b0) begin
            fails++; $display("FAIL basic_first_bit: got so=%b rdy=%b expected so=1 rdy=0", so_h[1], rdy_h[1]);
        end
        checks++; if (fr !== 2) begin
            fails++; $display("FAIL basic_first_rise: got %0d expected 2", fr);
        end
        checks++; if (fd !== 35 || nd !== 1) begin
            fails++; $display("FAIL basic_done: got at %0d count %0d expected at 35 count 1", fd, nd);
        end
        checks++; if (rdy_h[35] !== 1'b1 || rdy_h[34] !== 1'b0) begin
            fails++; $display("FAIL basic_ready_done: got %b%b expected 01", rdy_h[34], rdy_h[35]);
        end
    endtask

    task automatic test_half3();
        int nr, fr, fd, ld, nd, bad_lvl, bad_stab;
        logic [31:0] bits;
        a3 = 8'h03; d3 = 8'h55; v3 = 1'b1;
        fork
            capture(3, 105);
            begin @(posedge iclk); #2 v3 = 1'b0; end
        join
        analyze(105, nr, bits, fr, fd, ld, nd);
        bad_lvl = 0;
        bad_stab = 0;
        for (int k = 1; k <= 96; k++)
            if (sc_h[k] !== ((((k - 1) / 3) % 2) == 1)) bad_lvl++;
        for (int k = 97; k <= 105; k++)
            if (sc_h[k] !== 1'b0) bad_lvl++;
        for (int k = 4; k <= 105; k++) begin
            if (sc_h[k] && !sc_h[k-1] &&
                (so_h[k-1] !== so_h[k] || so_h[k-2] !== so_h[k] || so_h[k-3] !== so_h[k]))
                bad_stab++;
            if (sc_h[k] && so_h[k] !== so_h[k-1]) bad_stab++;
        end
        checks++; if (nr !== 16) begin
            fails++; $display("FAIL h3_rises: got %0d expected 16", nr);
        end
        checks++; if (fr !== 4) begin
            fails++; $display("FAIL h3_first_rise: got %0d expected 4", fr);
        end
        checks++; if (bad_lvl !== 0) begin
            fails++; $display("FAIL h3_sclk_levels: got %0d bad cycles expected 0", bad_lvl);
        end
        checks++; if (bad_stab !== 0) begin
            fails++; $display("FAIL h3_data_stable: got %0d violations expected 0", bad_stab);
        end
        checks++; if (bits[7:0] !== 8'h03) begin
            fails++; $display("FAIL h3_addr: got %h expected 03", bits[7:0]);
        end
        checks++; if (bits[15:8] !== 8'h55) begin
            fails++; $display("FAIL h3_mode: got %h expected 55", bits[15:8]);
        end
        checks++; if (fd !== 99 || nd !== 1) begin
            fails++; $display("FAIL h3_done: got at %0d count %0d expected at 99 count 1", fd, nd);
        end
    endtask

    task automatic test_back_to_back();
        int nr, fr, fd, ld, nd;
        logic [31:0] bits;
        a1 = 8'h02; d1 = 8'h0F; v1 = 1'b1;
        fork
            capture(1, 75);
            begin
                @(posedge iclk); #2 a1 = 8'h01; d1 = 8'hF0;
                repeat (35) @(posedge iclk);
                #2 v1 = 1'b0;
            end
        join
        analyze(75, nr, bits, fr, fd, ld, nd);
        checks++; if (nr !== 32) begin
            fails++; $display("FAIL b2b_rises: got %0d expected 32", nr);
        end
        checks++; if (bits !== 32'hF001_0F02) begin
            fails++; $display("FAIL b2b_bits: got %h expected f0010f02", bits);
        end
        checks++; if (fd !== 35 || ld !== 70 || nd !== 2) begin
            fails++; $display("FAIL b2b_done: got %0d/%0d count %0d expected 35/70 count 2", fd, ld, nd);
        end
        checks++; if (rdy_h[36] !== 1'b0 || so_h[36] !== 1'b1) begin
            fails++; $display("FAIL b2b_second_start: got rdy=%b so=%b expected rdy=0 so=1", rdy_h[36], so_h[36]);
        end
    endtask

    task automatic test_busy_reject();
        int nr, fr, fd, ld, nd;
        logic [31:0] bits;
        a1 = 8'h04; d1 = 8'h3C; v1 = 1'b1;
        fork
            capture(1, 40);
            begin
                @(posedge iclk); #2 v1 = 1'b0;
                repeat (9) @(posedge iclk);
                #2 v1 = 1'b1; a1 = 8'h07; d1 = 8'h00;
                @(posedge iclk); #2 v1 = 1'b0;
            end
        join
        analyze(40, nr, bits, fr, fd, ld, nd);
        checks++; if (nr !== 16 || bits[15:0] !== 16'h3C04) begin
            fails++; $display("FAIL busy_frame: got %0d rises bits %h expected 16 rises bits 3c04", nr, bits[15:0]);
        end
        checks++; if (fd !== 35 || nd !== 1) begin
            fails++; $display("FAIL busy_done: got at %0d count %0d expected at 35 count 1", fd, nd);
        end
    endtask

    task automatic test_reset_mid_frame();
        int nr, fr, fd, ld, nd;
        logic [31:0] bits;
        a1 = 8'h01; d1 = 8'hAA; v1 = 1'b1;
        fork
            capture(1, 40);
            begin
                @(posedge iclk); #2 v1 = 1'b0;
                repeat (10) @(posedge iclk);
                #2 rst = 1'b1;
                @(posedge iclk); #2 rst = 1'b0;
            end
        join
        analyze(40, nr, bits, fr, fd, ld, nd);
        checks++; if (nr !== 5) begin
            fails++; $display("FAIL abort_rises: got %0d expected 5", nr);
        end
        checks++; if ({sc_h[12], so_h[12], rdy_h[12]} !== 3'b001) begin
            fails++; $display("FAIL abort_idle: got %b expected 001", {sc_h[12], so_h[12], rdy_h[12]});
        end
        checks++; if (nd !== 0) begin
            fails++; $display("FAIL abort_no_done: got %0d expected 0", nd);
        end
        a1 = 8'h5A; d1 = 8'hC3; v1 = 1'b1;
        fork
            capture(1, 40);
            begin @(posedge iclk); #2 v1 = 1'b0; end
        join
        analyze(40, nr, bits, fr, fd, ld, nd);
        checks++; if (nr !== 16 || bits[15:0] !== 16'hC35A || fd !== 35) begin
            fails++; $display("FAIL abort_next_frame: got %0d rises bits %h done %0d expected 16 c35a 35", nr, bits[15:0], fd);
        end
    endtask

    task automatic test_rst_priority();
        int nr, fr, fd, ld, nd;
        logic [31:0] bits;
        rst = 1'b1; v1 = 1'b1; v3 = 1'b1;
        a1 = 8'hFF; d1 = 8'hFF; a3 = 8'hFF; d3 = 8'hFF;
        fork
            capture(1, 10);
            begin @(posedge iclk); #2 rst = 1'b0; v1 = 1'b0; v3 = 1'b0; end
        join
        analyze(10, nr, bits, fr, fd, ld, nd);
        checks++; if (rdy_h[1] !== 1'b1 || nr !== 0) begin
            fails++; $display("FAIL rstprio_no_accept: got rdy=%b rises=%0d expected rdy=1 rises=0", rdy_h[1], nr);
        end
        checks++; if ({dut1.sreg, dut1.bit_cnt, dut1.div_cnt} !== 29'd0) begin
            fails++; $display("FAIL rstprio_regs: got %h expected 0", {dut1.sreg, dut1.bit_cnt, dut1.div_cnt});
        end
        checks++; if (r3 !== 1'b1 || s3 !== 1'b0 || b3 !== 1'b0) begin
            fails++; $display("FAIL rstprio_h3: got rdy=%b sclk=%b busy=%b expected 1 0 0", r3, s3, b3);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_half3();
        test_back_to_back();
        test_busy_reject();
        test_reset_mid_frame();
        test_rst_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
